// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the registered accumulator ALU (alu_acc):
//   - FN_* : 3-bit operation-select codes carried on the Function port
//   - state_e : sequencing states (S_IDLE, S_MULT)
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] FN_ADD  = 3'b000;
    localparam logic [2:0] FN_ADDI = 3'b001;
    localparam logic [2:0] FN_PASS = 3'b010;
    localparam logic [2:0] FN_ORR  = 3'b011;
    localparam logic [2:0] FN_ANDR = 3'b100;
    localparam logic [2:0] FN_CAT  = 3'b101;
    localparam logic [2:0] FN_MUL  = 3'b110;
    localparam logic [2:0] FN_HOLD = 3'b111;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MULT = 1'b1
    } state_e;

endpackage

// File: rtl/ripple_adder.sv
// ---------------------------------------------------------------------------
// ripple_adder
// W-bit unsigned adder built as a chain of per-bit full adders.
// Ports:
//   a_i, b_i  : W-bit addends
//   cin_i     : carry into bit 0
//   sum_o     : W-bit sum
//   cout_o    : carry out of bit W-1
// ---------------------------------------------------------------------------
module ripple_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[W];

endmodule

// File: rtl/alu_acc.sv
// ---------------------------------------------------------------------------
// alu_acc
// Registered ALU with accumulator feedback and a multi-cycle shift-add
// multiplier sequenced under a Go/Busy/Done handshake.
// Ports:
//   Clock    : system clock, rising edge
//   Reset_b  : asynchronous active-low reset
//   A, B     : W-bit operands
//   UseAcc   : 1 selects ALUout[W-1:0] as operand B instead of port B
//   Function : operation select (FN_* in alu_pkg), sampled only with Go
//   Go       : start request, honoured only in S_IDLE
//   ALUout   : 2W-bit registered result
//   Zero     : registered, 1 when ALUout == 0
//   Busy     : 1 while a multiply is in progress
//   Done     : one-cycle pulse after each result write
// ---------------------------------------------------------------------------
module alu_acc
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           Clock,
    input  logic           Reset_b,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic           UseAcc,
    input  logic [2:0]     Function,
    input  logic           Go,
    output logic [2*W-1:0] ALUout,
    output logic           Zero,
    output logic           Busy,
    output logic           Done
);

    // Counter indexes multiplier bits 0..W-1; keep at least one bit for W=1.
    localparam int            CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_e           state_q, state_d;
    logic [2*W-1:0]   alu_q, alu_d;
    logic             zero_q;
    logic             done_q, done_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [2*W-1:0]   prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [W-1:0]     bop;
    logic [W-1:0]     add_sum;
    logic             add_cout;
    logic             start;
    logic             mul_last;
    logic [2*W-1:0]   partial;
    logic [2*W-1:0]   prod_next;

    assign bop   = UseAcc ? alu_q[W-1:0] : B;
    assign start = (state_q == S_IDLE) && Go;

    // One adder serves both ADD (cin 0) and ADDI (cin 1).
    ripple_adder #(.W(W)) u_adder (
        .a_i    (A),
        .b_i    (bop),
        .cin_i  (Function == FN_ADDI),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Shift-add step: product accumulates multiplicand << cnt when bit cnt is set.
    assign partial   = mplier_q[cnt_q] ? (mcand_q << cnt_q) : '0;
    assign prod_next = prod_q + partial;
    assign mul_last  = (state_q == S_MULT) && (cnt_q == CNT_LAST);

    // ---- FSM: state register ----
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ---- FSM: next-state logic ----
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (Go && Function == FN_MUL) state_d = S_MULT;
            S_MULT: if (cnt_q == CNT_LAST)        state_d = S_IDLE;
            default:                              state_d = S_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        Busy = (state_q == S_MULT);
    end

    // ---- Datapath next-state ----
    always_comb begin
        alu_d    = alu_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;

        if (start) begin
            done_d = (Function != FN_MUL);
            unique case (Function)
                FN_ADD, FN_ADDI: alu_d = {{(W-1){1'b0}}, add_cout, add_sum};
                FN_PASS: alu_d = {{W{1'b0}}, bop};
                FN_ORR:  alu_d = {{(2*W-1){1'b0}}, (|A) | (|bop)};
                FN_ANDR: alu_d = {{(2*W-1){1'b0}}, (&A) & (&bop)};
                FN_CAT:  alu_d = {bop, A};
                FN_MUL: begin
                    mcand_d  = {{W{1'b0}}, A};
                    mplier_d = bop;
                    prod_d   = '0;
                    cnt_d    = '0;
                end
                default: alu_d = alu_q;  // FN_HOLD
            endcase
        end else if (state_q == S_MULT) begin
            prod_d = prod_next;
            cnt_d  = cnt_q + CW'(1);
            if (mul_last) begin
                alu_d  = prod_next;
                done_d = 1'b1;
            end
        end
    end

    // ---- Datapath registers ----
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            alu_q    <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            alu_q    <= alu_d;
            zero_q   <= (alu_d == '0);
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ALUout = alu_q;
    assign Zero   = zero_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_alu_acc.sv
// ---------------------------------------------------------------------------
// tb_alu_acc
// Directed bench for alu_acc at W=4. Inputs change #1 after a rising edge;
// outputs are sampled #1 after a rising edge, away from the active edge.
// ---------------------------------------------------------------------------
module tb_alu_acc;
    import alu_pkg::*;

    localparam int W = 4;

    logic           Clock;
    logic           Reset_b;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           UseAcc;
    logic [2:0]     Function;
    logic           Go;
    logic [2*W-1:0] ALUout;
    logic           Zero;
    logic           Busy;
    logic           Done;

    int vectors;
    int miscompares;

    alu_acc #(.W(W)) dut (
        .Clock    (Clock),
        .Reset_b  (Reset_b),
        .A        (A),
        .B        (B),
        .UseAcc   (UseAcc),
        .Function (Function),
        .Go       (Go),
        .ALUout   (ALUout),
        .Zero     (Zero),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Present one operation with Go for a single edge, return #1 after it.
    task automatic issue(input logic [2:0] fn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic use_acc);
        Function = fn;
        A        = a;
        B        = b;
        UseAcc   = use_acc;
        Go       = 1'b1;
        @(posedge Clock);
        #1;
        Go = 1'b0;
    endtask

    task automatic test_reset();
        Reset_b = 1'b0;
        #12;
        vectors++;
        if (ALUout !== 8'h00 || Zero !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got ALUout=%h Zero=%b Busy=%b Done=%b want 00 1 0 0",
                     ALUout, Zero, Busy, Done);
        end
        @(negedge Clock);
        Reset_b = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_add();
        issue(FN_ADD, 4'h3, 4'h1, 1'b0);
        vectors++;
        if (ALUout !== 8'h04 || Zero !== 1'b0 || Done !== 1'b1 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL add_3_1: got ALUout=%h Zero=%b Done=%b Busy=%b want 04 0 1 0",
                     ALUout, Zero, Done, Busy);
        end
        @(posedge Clock);
        #1;
        vectors++;
        if (Done !== 1'b0 || ALUout !== 8'h04) begin
            miscompares++;
            $display("FAIL add_done_pulse: got Done=%b ALUout=%h want 0 04", Done, ALUout);
        end
    endtask

    task automatic test_accumulate();
        issue(FN_PASS, 4'h0, 4'h5, 1'b0);
        vectors++;
        if (ALUout !== 8'h05) begin
            miscompares++;
            $display("FAIL passb_5: got %h want 05", ALUout);
        end
        issue(FN_ADD, 4'h3, 4'h0, 1'b1);
        vectors++;
        if (ALUout !== 8'h08) begin
            miscompares++;
            $display("FAIL acc_add_3: got %h want 08", ALUout);
        end
        issue(FN_ADD, 4'hF, 4'h0, 1'b1);
        vectors++;
        if (ALUout !== 8'h17 || Zero !== 1'b0) begin
            miscompares++;
            $display("FAIL acc_add_carry: got ALUout=%h Zero=%b want 17 0", ALUout, Zero);
        end
    endtask

    task automatic test_mul();
        issue(FN_MUL, 4'hF, 4'hF, 1'b0);
        vectors++;
        if (Busy !== 1'b1 || Done !== 1'b0 || ALUout !== 8'h17) begin
            miscompares++;
            $display("FAIL mul_start: got Busy=%b Done=%b ALUout=%h want 1 0 17",
                     Busy, Done, ALUout);
        end
        for (int i = 1; i < W; i++) begin
            @(posedge Clock);
            #1;
            vectors++;
            if (Busy !== 1'b1 || Done !== 1'b0 || ALUout !== 8'h17) begin
                miscompares++;
                $display("FAIL mul_busy_%0d: got Busy=%b Done=%b ALUout=%h want 1 0 17",
                         i, Busy, Done, ALUout);
            end
            if (i == 1) begin
                Function = FN_ADD;
                A        = 4'h1;
                B        = 4'h1;
                Go       = 1'b1;
            end else if (i == 2) begin
                Go = 1'b0;
            end
        end
        @(posedge Clock);
        #1;
        vectors++;
        if (ALUout !== 8'hE1 || Done !== 1'b1 || Busy !== 1'b0 || Zero !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_F_F: got ALUout=%h Done=%b Busy=%b Zero=%b want E1 1 0 0",
                     ALUout, Done, Busy, Zero);
        end
        @(posedge Clock);
        #1;
        vectors++;
        if (ALUout !== 8'hE1 || Done !== 1'b0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_after: got ALUout=%h Done=%b Busy=%b want E1 0 0",
                     ALUout, Done, Busy);
        end
    endtask

    task automatic test_reduce_cat();
        issue(FN_ORR, 4'h0, 4'h0, 1'b0);
        vectors++;
        if (ALUout !== 8'h00 || Zero !== 1'b1) begin
            miscompares++;
            $display("FAIL orr_0_0: got ALUout=%h Zero=%b want 00 1", ALUout, Zero);
        end
        issue(FN_ORR, 4'h0, 4'h2, 1'b0);
        vectors++;
        if (ALUout !== 8'h01 || Zero !== 1'b0) begin
            miscompares++;
            $display("FAIL orr_0_2: got ALUout=%h Zero=%b want 01 0", ALUout, Zero);
        end
        issue(FN_ANDR, 4'hF, 4'hF, 1'b0);
        vectors++;
        if (ALUout !== 8'h01) begin
            miscompares++;
            $display("FAIL andr_F_F: got %h want 01", ALUout);
        end
        issue(FN_ANDR, 4'hF, 4'hE, 1'b0);
        vectors++;
        if (ALUout !== 8'h00 || Zero !== 1'b1) begin
            miscompares++;
            $display("FAIL andr_F_E: got ALUout=%h Zero=%b want 00 1", ALUout, Zero);
        end
        issue(FN_CAT, 4'h3, 4'hA, 1'b0);
        vectors++;
        if (ALUout !== 8'hA3) begin
            miscompares++;
            $display("FAIL cat_3_A: got %h want A3", ALUout);
        end
    endtask

    task automatic test_hold_back_to_back();
        issue(FN_CAT, 4'hC, 4'h3, 1'b0);
        vectors++;
        if (ALUout !== 8'h3C) begin
            miscompares++;
            $display("FAIL cat_C_3: got %h want 3C", ALUout);
        end
        issue(FN_HOLD, 4'h5, 4'h5, 1'b0);
        vectors++;
        if (ALUout !== 8'h3C || Done !== 1'b1 || Zero !== 1'b0) begin
            miscompares++;
            $display("FAIL hold: got ALUout=%h Done=%b Zero=%b want 3C 1 0",
                     ALUout, Done, Zero);
        end
        // Go held for three edges: low nibble C feeds back, +1 each edge.
        Function = FN_ADDI;
        A        = 4'h0;
        B        = 4'h0;
        UseAcc   = 1'b1;
        Go       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock);
            #1;
            vectors++;
            if (ALUout !== 8'(8'h0D + i) || Done !== 1'b1) begin
                miscompares++;
                $display("FAIL addi_held_%0d: got ALUout=%h Done=%b want %h 1",
                         i, ALUout, Done, 8'(8'h0D + i));
            end
        end
        Go = 1'b0;
        @(posedge Clock);
        #1;
        vectors++;
        if (ALUout !== 8'h0F || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL addi_release: got ALUout=%h Done=%b want 0F 0", ALUout, Done);
        end
    endtask

    task automatic test_mul_abort();
        issue(FN_MUL, 4'h7, 4'h5, 1'b0);
        @(posedge Clock);
        @(posedge Clock);
        #3;
        Reset_b = 1'b0;
        #1;
        vectors++;
        if (ALUout !== 8'h00 || Zero !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_reset: got ALUout=%h Zero=%b Busy=%b Done=%b want 00 1 0 0",
                     ALUout, Zero, Busy, Done);
        end
        @(negedge Clock);
        Reset_b = 1'b1;
        @(posedge Clock);
        #1;
        issue(FN_ADD, 4'h2, 4'h2, 1'b0);
        vectors++;
        if (ALUout !== 8'h04 || Done !== 1'b1 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_then_add: got ALUout=%h Done=%b Busy=%b want 04 1 0",
                     ALUout, Done, Busy);
        end
        repeat (W + 1) @(posedge Clock);
        #1;
        vectors++;
        if (ALUout !== 8'h04 || Done !== 1'b0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_residue: got ALUout=%h Done=%b Busy=%b want 04 0 0",
                     ALUout, Done, Busy);
        end
    endtask

    task automatic test_mul_small();
        issue(FN_MUL, 4'h7, 4'h5, 1'b0);
        repeat (W) @(posedge Clock);
        #1;
        vectors++;
        if (ALUout !== 8'h23 || Done !== 1'b1) begin
            miscompares++;
            $display("FAIL mul_7_5: got ALUout=%h Done=%b want 23 1", ALUout, Done);
        end
        issue(FN_MUL, 4'h9, 4'h0, 1'b0);
        repeat (W) @(posedge Clock);
        #1;
        vectors++;
        if (ALUout !== 8'h00 || Zero !== 1'b1 || Done !== 1'b1) begin
            miscompares++;
            $display("FAIL mul_9_0: got ALUout=%h Zero=%b Done=%b want 00 1 1",
                     ALUout, Zero, Done);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        A           = '0;
        B           = '0;
        UseAcc      = 1'b0;
        Function    = FN_ADD;
        Go          = 1'b0;
        Reset_b     = 1'b0;

        test_reset();
        test_add();
        test_accumulate();
        test_mul();
        test_reduce_cat();
        test_hold_back_to_back();
        test_mul_abort();
        test_mul_small();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
